// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and pointer-derived full/empty flags.
// Optional macro SYNC_FIFO_ERR_EN adds registered overflow/underflow pulse outputs.
module sync_fifo #(
   parameter int datawidth = 8,
   parameter int depth     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wen,
   input  logic                 ren,
   input  logic [datawidth-1:0] din,
   output logic [datawidth-1:0] dout,
   output logic                 full,
   output logic                 empty
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                 overflow,
   output logic                 underflow
`endif
);

   localparam int aw = $clog2(depth);
   localparam logic [aw:0] ptr_one = (aw + 1)'(1);

   if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_depth_check
      $error("sync_fifo: depth must be a power of two and at least 2");
   end

   logic [datawidth-1:0] mem [depth];
   logic [aw:0]          wr_ptr;
   logic [aw:0]          rd_ptr;
   logic                 wr_acc;
   logic                 rd_acc;

   // Request/accept: a write is taken when wen=1 and not full, a read when
   // ren=1 and not empty; refused requests leave all state untouched.
   // The flags depend only on registered pointers, never on wen/ren.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
   assign wr_acc = wen && !full;
   assign rd_acc = ren && !empty;

   // Storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst && wr_acc) begin
         mem[wr_ptr[aw-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ptr_one;
         end
         if (rd_acc) begin
            dout   <= mem[rd_ptr[aw-1:0]];
            rd_ptr <= rd_ptr + ptr_one;
         end
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wen && full;
         underflow <= ren && empty;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a directed vector table plus hand-written
// corner-case sequences checked against a queue model.
module tb_sync_fifo;

   localparam int W     = 8;
   localparam int DEPTH = 8;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         wen = 1'b0;
   logic         ren = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout;
   logic         full;
   logic         empty;
   logic         overflow;
   logic         underflow;

   always #5 clk = ~clk;

`ifdef SYNC_FIFO_ERR_EN
   sync_fifo #(.datawidth(W), .depth(DEPTH)) dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din),
      .dout(dout), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow)
   );
`else
   sync_fifo #(.datawidth(W), .depth(DEPTH)) dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din),
      .dout(dout), .full(full), .empty(empty)
   );
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_dout;

   typedef struct {
      logic         rst;
      logic         wen;
      logic         ren;
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic         empty;
      logic         full;
      logic         ovf;
      logic         unf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic drive(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
      @(negedge clk);
      rst = r;
      wen = w;
      ren = rd;
      din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic w, input logic rd, input logic [W-1:0] d,
                      input logic [W-1:0] q, input logic e, input logic f,
                      input logic o, input logic u);
      vec_t v;
      v.rst = r; v.wen = w; v.ren = rd; v.din = d;
      v.dout = q; v.empty = e; v.full = f; v.ovf = o; v.unf = u;
      vecs.push_back(v);
   endtask

   // One model-checked cycle for the hand-written sequences.
   task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
      logic wr_ok, rd_ok, e_ovf, e_unf;
      wr_ok = w && (exp_q.size() < DEPTH);
      rd_ok = r && (exp_q.size() > 0);
      e_ovf = w && (exp_q.size() == DEPTH);
      e_unf = r && (exp_q.size() == 0);
      if (rd_ok) exp_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      drive(1'b1, w, r, d);
      check("seq_dout", dout, exp_dout);
      check("seq_empty", empty, exp_q.size() == 0);
      check("seq_full", full, exp_q.size() == DEPTH);
`ifdef SYNC_FIFO_ERR_EN
      check("seq_overflow", overflow, e_ovf);
      check("seq_underflow", underflow, e_unf);
`endif
   endtask

   task automatic reset_cycle(input logic w, input logic [W-1:0] d);
      exp_q.delete();
      exp_dout = '0;
      drive(1'b0, w, 1'b0, d);
      check("rst_dout", dout, exp_dout);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset for 4 cycles; the last one also requests a write that must be ignored.
      for (int i = 0; i < 4; i++) add(1'b0, i == 3, 1'b0, 8'hAB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      // Basic write 0x11..0x66, then read them back.
      for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 1'b0, W'(8'h11 * (i + 1)), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 1'b1, 8'h00, W'(8'h11 * (i + 1)), i == 5, 1'b0, 1'b0, 1'b0);
      // Fill with 0x01..0x08, overflow attempt, drain.
      for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 1'b0, W'(i + 1), 8'h66, 1'b0, i == 7, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 8'hFF, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 1'b1, 8'h00, W'(i + 1), i == 7, 1'b0, 1'b0, 1'b0);
      // Underflow: dout holds, empty stays set; then an idle cycle clears the pulse.
      add(1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].wen, vecs[i].ren, vecs[i].din);
         check($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
         check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
         check($sformatf("vec%0d_full", i), full, vecs[i].full);
`ifdef SYNC_FIFO_ERR_EN
         check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
         check($sformatf("vec%0d_underflow", i), underflow, vecs[i].unf);
`endif
      end

      // Model picks up from the table's end state: empty, dout = 0x08.
      exp_q.delete();
      exp_dout = 8'h08;

      // Wrap-around: pointers cross the memory boundary several times.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(8'h30 + i));
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(8'hA0 + i));
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, W'(8'hB0 + i));
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00);

      // Simultaneous access at empty: write only, dout unchanged, occupancy 1.
      cycle(1'b1, 1'b1, 8'hC0);
      cycle(1'b0, 1'b1, 8'h00);

      // Simultaneous access at full: read only, write dropped, occupancy 7.
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(8'hD0 + i));
      cycle(1'b1, 1'b1, 8'hEE);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h00);

      // Reset mid-operation discards stored words; a write during reset is ignored.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(8'h70 + i));
      cycle(1'b0, 1'b1, 8'h00);
      reset_cycle(1'b1, 8'h77);
      cycle(1'b1, 1'b0, 8'h5A);
      cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
